// File: rtl/fdiv_pkg.sv
// Shared types and constants for the sequential FP divider wrapper.
// Flag vector layout is {NV,DZ,OF,UF,NX}.
package fdiv_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fdiv_state_e;

  localparam int FLAG_W  = 5;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN = 32'hFFC00000;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
  } fdiv_opnd_t;
endpackage

// File: rtl/fdiv_seq_if.sv
// Operand and result handshake channels of fdiv_seq.
interface fdiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rslt;
  logic [4:0]  out_flag;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_rslt, out_flag
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_rslt, out_flag
  );
endinterface

// File: rtl/fdiv_opq.sv
// Operand FIFO: QDEPTH {x,y} entries, pointers carry an extra wrap bit
// so full and empty are told apart without a separate counter.
module fdiv_opq
  import fdiv_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  fdiv_opnd_t push_data,
  input  logic       pop,
  output fdiv_opnd_t pop_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  fdiv_opnd_t  mem [QDEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A push on a full queue is only taken when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/fdiv_seq.sv
// Sequencer around a fixed-latency FP divider core: queues operands, issues one
// op at a time, holds each result until taken. FDIV_FFLAGS_EN adds sticky fflags.
module fdiv_seq
  import fdiv_pkg::*;
#(
  parameter int DIV_LAT = 26,
  parameter int QDEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  fdiv_seq_if.slave         bus,
  output logic              div_start,
  output logic [31:0]       div_x,
  output logic [31:0]       div_y,
  input  logic [31:0]       div_rslt,
  input  logic [FLAG_W-1:0] div_flag,
  output logic              busy
`ifdef FDIV_FFLAGS_EN
  ,
  input  logic              fflags_clr,
  output logic [FLAG_W-1:0] fflags
`endif
);
  localparam logic [5:0] LAT = 6'(DIV_LAT);

  fdiv_state_e       state_reg, state_next;
  logic [5:0]        cnt_reg;
  logic              div_start_reg;
  logic [31:0]       div_x_reg, div_y_reg;
  logic              out_valid_reg;
  logic [31:0]       out_rslt_reg;
  logic [FLAG_W-1:0] out_flag_reg;

  logic       q_full, q_empty, q_push, q_pop, capture;
  fdiv_opnd_t q_head, q_in;

  assign q_in   = '{x: bus.in_x, y: bus.in_y};
  assign q_push = bus.in_valid && !q_full;

  fdiv_opq #(.QDEPTH(QDEPTH)) u_opq (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    state_next = state_reg;
    q_pop      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        // Issue only when the output slot is free or is being emptied now.
        if (!q_empty && (!out_valid_reg || bus.out_ready)) begin
          q_pop      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      div_start_reg <= 1'b0;
      div_x_reg     <= '0;
      div_y_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_rslt_reg  <= '0;
      out_flag_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      div_start_reg <= q_pop;
      // The counter is already at DIV_LAT while div_start is high.
      if (q_pop) begin
        div_x_reg <= q_head.x;
        div_y_reg <= q_head.y;
        cnt_reg   <= LAT;
      end else if (state_reg == BUSY && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (capture) begin
        out_valid_reg <= 1'b1;
        out_rslt_reg  <= div_rslt;
        out_flag_reg  <= div_flag;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FDIV_FFLAGS_EN
  logic [FLAG_W-1:0] fflags_reg;
  logic              out_hs;
  assign out_hs = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fflags_reg <= '0;
    end else if (fflags_clr) begin
      fflags_reg <= out_hs ? out_flag_reg : '0;
    end else if (out_hs) begin
      fflags_reg <= fflags_reg | out_flag_reg;
    end
  end

  assign fflags = fflags_reg;
`endif

  assign bus.in_ready  = !q_full;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_rslt  = out_rslt_reg;
  assign bus.out_flag  = out_flag_reg;
  assign div_start     = div_start_reg;
  assign div_x         = div_x_reg;
  assign div_y         = div_y_reg;
  assign busy          = !q_empty || (state_reg == BUSY) || out_valid_reg;
endmodule
